// File: rtl/bram_arbiter_if.sv
// rtl/bram_arbiter_if.sv - requester and RAM bus bundle for the BRAM arbiter
// Purpose: groups the instruction port, data port and byte-enabled RAM signals.
// Ports (modports):
//   slave  - arbiter side: takes requests and ram_data_out; drives acks, read data, RAM controls.
//   master - requester/RAM side: the mirror image of slave.
interface bram_arbiter_if #(
  parameter int ADDRESS_BITWIDTH = 16
);
  logic                        i_req;
  logic [ADDRESS_BITWIDTH+1:0] i_addr;
  logic                        i_ack;
  logic [31:0]                 i_rdata;

  logic                        d_req;
  logic                        d_we;
  logic [1:0]                  d_size;
  logic                        d_signed;
  logic [ADDRESS_BITWIDTH+1:0] d_addr;
  logic [31:0]                 d_wdata;
  logic                        d_ack;
  logic [31:0]                 d_rdata;
  logic                        d_err;

  logic [3:0]                  ram_write_enable;
  logic [ADDRESS_BITWIDTH-1:0] ram_address;
  logic [31:0]                 ram_data_in;
  logic [31:0]                 ram_data_out;

  modport slave (
    input  i_req, i_addr, d_req, d_we, d_size, d_signed, d_addr, d_wdata, ram_data_out,
    output i_ack, i_rdata, d_ack, d_rdata, d_err, ram_write_enable, ram_address, ram_data_in
  );

  modport master (
    output i_req, i_addr, d_req, d_we, d_size, d_signed, d_addr, d_wdata, ram_data_out,
    input  i_ack, i_rdata, d_ack, d_rdata, d_err, ram_write_enable, ram_address, ram_data_in
  );
endinterface

// File: rtl/bram_arbiter.sv
// rtl/bram_arbiter.sv - two-port (instruction/data) arbiter onto one byte-enabled BRAM
// Purpose: grants one requester per two-cycle slot (IDLE grant, ACK completion), steers
//          address/write data/byte enables to the RAM and returns registered read data.
// Ports:
//   clk  - single clock, rising edge.
//   rst  - synchronous active-high reset.
//   bus  - bram_arbiter_if.slave: instruction port, data port and RAM signals.
module bram_arbiter #(
  parameter int ADDRESS_BITWIDTH = 16
) (
  input  logic                clk,
  input  logic                rst,
  bram_arbiter_if.slave       bus
);
  localparam int AW = ADDRESS_BITWIDTH;

  typedef enum logic {IDLE, ACK} state_t;
  localparam logic PORT_I = 1'b0;
  localparam logic PORT_D = 1'b1;

  state_t      state_q, state_d;
  logic        last_grant_q, last_grant_d;
  logic        ack_port_q, ack_port_d;
  logic        err_q, err_d;
  logic [31:0] i_rdata_q, i_rdata_d;
  logic [31:0] d_rdata_q, d_rdata_d;

  logic        grant_i, grant_d;
  logic        misaligned;
  logic [3:0]  byte_en;
  logic [4:0]  lane_shift;
  logic [31:0] lane_word;
  logic [31:0] read_ext;
  logic        ack_live;

  // The instruction port's byte offset is meaningless for word fetches.
  logic        unused_i_addr_bits;
  assign unused_i_addr_bits = ^bus.i_addr[1:0];

  always_comb begin
    grant_i = 1'b0;
    grant_d = 1'b0;
    if (state_q == IDLE) begin
      if (bus.i_req && bus.d_req) begin
        // Conflict: the port that did not win last time goes now.
        if (last_grant_q == PORT_D) grant_i = 1'b1;
        else                        grant_d = 1'b1;
      end else if (bus.i_req) begin
        grant_i = 1'b1;
      end else if (bus.d_req) begin
        grant_d = 1'b1;
      end
    end
  end

  // Lane selection shared by write steering and read extraction.
  always_comb begin
    misaligned = 1'b0;
    byte_en    = 4'b1111;
    lane_shift = 5'd0;
    case (bus.d_size)
      2'b00: begin
        byte_en    = 4'b0001 << bus.d_addr[1:0];
        lane_shift = {bus.d_addr[1:0], 3'b000};
      end
      2'b01: begin
        misaligned = bus.d_addr[0];
        byte_en    = 4'b0011 << {bus.d_addr[1], 1'b0};
        lane_shift = {bus.d_addr[1], 4'b0000};
      end
      default: begin
        misaligned = (bus.d_addr[1:0] != 2'b00);
      end
    endcase
  end

  always_comb begin
    lane_word = bus.ram_data_out >> lane_shift;
    case (bus.d_size)
      2'b00:   read_ext = {{24{bus.d_signed & lane_word[7]}}, lane_word[7:0]};
      2'b01:   read_ext = {{16{bus.d_signed & lane_word[15]}}, lane_word[15:0]};
      default: read_ext = lane_word;
    endcase
  end

  always_comb begin
    bus.ram_address      = grant_d ? bus.d_addr[AW+1:2] : bus.i_addr[AW+1:2];
    bus.ram_data_in      = bus.d_wdata << lane_shift;
    bus.ram_write_enable = (grant_d && bus.d_we && !misaligned && !rst) ? byte_en : 4'b0000;
  end

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    ack_port_d   = ack_port_q;
    err_d        = err_q;
    i_rdata_d    = i_rdata_q;
    d_rdata_d    = d_rdata_q;
    case (state_q)
      IDLE: begin
        if (grant_i) begin
          state_d      = ACK;
          last_grant_d = PORT_I;
          ack_port_d   = PORT_I;
          i_rdata_d    = bus.ram_data_out;
        end else if (grant_d) begin
          state_d      = ACK;
          last_grant_d = PORT_D;
          ack_port_d   = PORT_D;
          err_d        = misaligned;
          d_rdata_d    = misaligned ? 32'd0 : read_ext;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      last_grant_q <= PORT_D;
      ack_port_q   <= PORT_I;
      err_q        <= 1'b0;
      i_rdata_q    <= 32'd0;
      d_rdata_q    <= 32'd0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      ack_port_q   <= ack_port_d;
      err_q        <= err_d;
      i_rdata_q    <= i_rdata_d;
      d_rdata_q    <= d_rdata_d;
    end
  end

  // Gating with rst lets a reset landing in the ACK cycle swallow the ack.
  assign ack_live    = (state_q == ACK) && !rst;
  assign bus.i_ack   = ack_live && (ack_port_q == PORT_I);
  assign bus.d_ack   = ack_live && (ack_port_q == PORT_D);
  assign bus.d_err   = bus.d_ack && err_q;
  assign bus.i_rdata = i_rdata_q;
  assign bus.d_rdata = d_rdata_q;
endmodule

// File: tb/tb_bram_arbiter.sv
// tb/tb_bram_arbiter.sv - self-checking bench for bram_arbiter
module tb_bram_arbiter;
  logic clk;
  logic rst;
  int   tests;
  int   failed;

  bram_arbiter_if #(.ADDRESS_BITWIDTH(16)) bus ();

  bram_arbiter #(.ADDRESS_BITWIDTH(16)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [31:0] mem [16];
  logic        mem_clr;
  assign bus.ram_data_out = mem[bus.ram_address[3:0]];

  always @(posedge clk) begin
    if (mem_clr) begin
      for (int k = 0; k < 16; k++) mem[k] <= 32'd0;
    end else begin
      for (int b = 0; b < 4; b++)
        if (bus.ram_write_enable[b]) mem[bus.ram_address[3:0]][8*b +: 8] <= bus.ram_data_in[8*b +: 8];
    end
  end

  typedef struct {
    logic        we;
    logic [1:0]  size;
    logic        sgn;
    logic [17:0] addr;
    logic [31:0] wdata;
    logic [3:0]  exp_we;
    logic [15:0] exp_addr;
    logic [31:0] exp_din;
    logic        exp_err;
    logic [31:0] exp_rdata;
  } vec_t;

  vec_t vecs [13];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  initial begin
    tests   = 0;
    failed  = 0;
    mem_clr = 1'b1;
    rst     = 1'b1;
    bus.i_req    = 1'b0;
    bus.i_addr   = '0;
    bus.d_req    = 1'b1;
    bus.d_we     = 1'b1;
    bus.d_size   = 2'b10;
    bus.d_signed = 1'b0;
    bus.d_addr   = 18'h00004;
    bus.d_wdata  = 32'h11111111;

    //            we    size   sgn   addr       wdata          exp_we   addr  din            err   rdata
    vecs[0]  = '{1'b1, 2'b00, 1'b0, 18'h00006, 32'h000000A5, 4'b0100, 16'd1, 32'h00A50000, 1'b0, 32'h00000000};
    vecs[1]  = '{1'b0, 2'b00, 1'b1, 18'h00006, 32'h00000000, 4'b0000, 16'd1, 32'h00000000, 1'b0, 32'hFFFFFFA5};
    vecs[2]  = '{1'b0, 2'b00, 1'b0, 18'h00006, 32'h00000000, 4'b0000, 16'd1, 32'h00000000, 1'b0, 32'h000000A5};
    vecs[3]  = '{1'b1, 2'b10, 1'b0, 18'h00002, 32'hDEADBEEF, 4'b0000, 16'd0, 32'hDEADBEEF, 1'b1, 32'h00000000};
    vecs[4]  = '{1'b1, 2'b01, 1'b0, 18'h00002, 32'h00001234, 4'b1100, 16'd0, 32'h12340000, 1'b0, 32'h00000000};
    vecs[5]  = '{1'b0, 2'b01, 1'b0, 18'h00002, 32'h00000000, 4'b0000, 16'd0, 32'h00000000, 1'b0, 32'h00001234};
    vecs[6]  = '{1'b1, 2'b10, 1'b0, 18'h00008, 32'h80FF7F01, 4'b1111, 16'd2, 32'h80FF7F01, 1'b0, 32'h00000000};
    vecs[7]  = '{1'b0, 2'b01, 1'b1, 18'h00008, 32'h00000000, 4'b0000, 16'd2, 32'h00000000, 1'b0, 32'h00007F01};
    vecs[8]  = '{1'b0, 2'b01, 1'b1, 18'h0000A, 32'h00000000, 4'b0000, 16'd2, 32'h00000000, 1'b0, 32'hFFFF80FF};
    vecs[9]  = '{1'b0, 2'b00, 1'b1, 18'h0000B, 32'h00000000, 4'b0000, 16'd2, 32'h00000000, 1'b0, 32'hFFFFFF80};
    vecs[10] = '{1'b0, 2'b01, 1'b0, 18'h00009, 32'h00000000, 4'b0000, 16'd2, 32'h00000000, 1'b1, 32'h00000000};
    vecs[11] = '{1'b1, 2'b00, 1'b0, 18'h0000B, 32'h000000CC, 4'b1000, 16'd2, 32'hCC000000, 1'b0, 32'h00000000};
    vecs[12] = '{1'b0, 2'b11, 1'b0, 18'h00008, 32'h00000000, 4'b0000, 16'd2, 32'h00000000, 1'b0, 32'hCCFF7F01};

    // Reset held while a word-write grant condition is present.
    @(negedge clk);
    #1;
    chk("rst_we_gated", {28'd0, bus.ram_write_enable}, 32'd0);
    @(negedge clk);
    #1;
    chk("rst_we_gated2", {28'd0, bus.ram_write_enable}, 32'd0);
    chk("rst_i_ack", {31'd0, bus.i_ack}, 32'd0);
    chk("rst_d_ack", {31'd0, bus.d_ack}, 32'd0);
    chk("rst_d_err", {31'd0, bus.d_err}, 32'd0);
    chk("rst_i_rdata", bus.i_rdata, 32'd0);
    chk("rst_d_rdata", bus.d_rdata, 32'd0);
    mem_clr   = 1'b0;
    bus.d_req = 1'b0;
    rst       = 1'b0;
    @(negedge clk);
    #1;
    chk("rst_no_d_ack", {31'd0, bus.d_ack}, 32'd0);

    for (int i = 0; i < 13; i++) begin
      @(negedge clk);
      bus.d_we     = vecs[i].we;
      bus.d_size   = vecs[i].size;
      bus.d_signed = vecs[i].sgn;
      bus.d_addr   = vecs[i].addr;
      bus.d_wdata  = vecs[i].wdata;
      bus.d_req    = 1'b1;
      #1;
      chk($sformatf("v%0d_we", i), {28'd0, bus.ram_write_enable}, {28'd0, vecs[i].exp_we});
      chk($sformatf("v%0d_addr", i), {16'd0, bus.ram_address}, {16'd0, vecs[i].exp_addr});
      chk($sformatf("v%0d_din", i), bus.ram_data_in, vecs[i].exp_din);
      chk($sformatf("v%0d_ack_early", i), {31'd0, bus.d_ack}, 32'd0);
      @(negedge clk);
      #1;
      chk($sformatf("v%0d_ack", i), {31'd0, bus.d_ack}, 32'd1);
      chk($sformatf("v%0d_i_ack", i), {31'd0, bus.i_ack}, 32'd0);
      chk($sformatf("v%0d_err", i), {31'd0, bus.d_err}, {31'd0, vecs[i].exp_err});
      if (!vecs[i].we || vecs[i].exp_err)
        chk($sformatf("v%0d_rdata", i), bus.d_rdata, vecs[i].exp_rdata);
      chk($sformatf("v%0d_no_grant_in_ack", i), {28'd0, bus.ram_write_enable}, 32'd0);
      bus.d_req = 1'b0;
    end

    // Instruction fetch; low address bits must be ignored, d_rdata must hold.
    @(negedge clk);
    bus.i_addr = 18'h0000B;
    bus.i_req  = 1'b1;
    #1;
    chk("ifetch_addr", {16'd0, bus.ram_address}, 32'd2);
    @(negedge clk);
    #1;
    chk("ifetch_ack", {31'd0, bus.i_ack}, 32'd1);
    chk("ifetch_d_ack", {31'd0, bus.d_ack}, 32'd0);
    chk("ifetch_rdata", bus.i_rdata, 32'hCCFF7F01);
    chk("d_rdata_hold", bus.d_rdata, 32'hCCFF7F01);
    bus.i_req = 1'b0;

    // Reset arriving in the ACK cycle swallows the ack.
    @(negedge clk);
    bus.d_we   = 1'b0;
    bus.d_size = 2'b10;
    bus.d_addr = 18'h00008;
    bus.d_req  = 1'b1;
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("rst_in_ack_d_ack", {31'd0, bus.d_ack}, 32'd0);
    bus.d_req = 1'b0;
    @(negedge clk);
    rst = 1'b0;

    // Word 1 must not have been written by the write presented during reset.
    chk("rst_write_blocked", mem[1], 32'h00A50000);

    // Conflict from reset release: instruction first, then alternate.
    @(negedge clk);
    rst        = 1'b1;
    bus.i_addr = 18'h00008;
    bus.i_req  = 1'b1;
    bus.d_we   = 1'b0;
    bus.d_size = 2'b10;
    bus.d_addr = 18'h00004;
    bus.d_req  = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    for (int c = 1; c <= 6; c++) begin
      if (c > 1) @(negedge clk);
      #1;
      chk($sformatf("conf_c%0d_i_ack", c), {31'd0, bus.i_ack}, {31'd0, (c == 2 || c == 6)});
      chk($sformatf("conf_c%0d_d_ack", c), {31'd0, bus.d_ack}, {31'd0, (c == 4)});
      if (c == 2) chk("conf_i_rdata", bus.i_rdata, 32'hCCFF7F01);
      if (c == 4) chk("conf_d_rdata", bus.d_rdata, 32'h00A50000);
    end
    bus.i_req = 1'b0;
    bus.d_req = 1'b0;
    @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end
endmodule
